// File: rtl/timer_pkg.sv
// timer_pkg: shared address map, CTRL bit positions, mode encodings and FSM states for interval_timer
package timer_pkg;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PS   = 4;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits a tick every div_i+1 cycles while clr_i is low
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o,
  output logic         unused_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // >= rather than == so a divisor lowered mid-count cannot force a full wrap
  assign tick_o = cnt_q >= div_i;
  assign unused_o = 1'b0;
  // next prescale count: restart on clear or after each tick
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  // prescale counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/interval_timer.sv
// interval_timer: memory-mapped countdown timer with one-shot/auto-reload IRQ; TIMER_PRESCALE_EN adds a CTRL prescale divisor
module interval_timer
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'd0,
  parameter int          PRESCALE_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Addr,
  input  logic        Write_Enabled,
  input  logic [31:0] Data_In,
  output logic [31:0] Data_Out,
  output logic        IRQ
);
  state_e      state_q, state_d;
  logic        en_q, en_d, im_q, im_d, irq_q, irq_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] preset_q, preset_d, count_q, count_d, ctrl_rd;
  logic        tick, ctrl_wr, unused_di;
  assign ctrl_wr = Write_Enabled && Addr == ADDR_CTRL;
  assign unused_di = ^Data_In;
`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic                  unused_ps;
  timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != CNT || !en_q),
    .div_i   (div_q),
    .tick_o  (tick),
    .unused_o(unused_ps)
  );
  assign ctrl_rd = 32'({div_q, im_q, mode_q, en_q});
  // divisor register
  always_ff @(posedge clk or posedge rst)
    if (rst) div_q <= '0;
    else div_q <= div_d;
  // divisor is written with the rest of CTRL
  always_comb div_d = ctrl_wr ? Data_In[CTRL_PS +: PRESCALE_W] : div_q;
`else
  localparam int unused_pw = PRESCALE_W;
  assign tick = 1'b1;
  assign ctrl_rd = {28'd0, im_q, mode_q, en_q};
`endif
  assign IRQ = irq_q & im_q;
  assign Data_Out = Addr == ADDR_CTRL   ? ctrl_rd  :
                    Addr == ADDR_PRESET ? preset_q :
                    Addr == ADDR_COUNT  ? count_q  : 32'd0;
  // FSM next state, then bus writes applied last so they win same-edge conflicts
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    irq_d    = irq_q;
    preset_d = preset_q;
    count_d  = count_q;
    case (state_q)
      IDLE: state_d = en_q ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) state_d = IDLE;
        else if (tick) begin
          count_d = count_q > 32'd1 ? count_q - 32'd1 : 32'd0;
          irq_d   = count_q <= 32'd1 ? 1'b1 : irq_q;
          state_d = count_q <= 32'd1 ? INT : CNT;
        end
      end
      INT: begin
        irq_d   = mode_q == MODE_RELOAD ? 1'b0 : irq_q;
        en_d    = mode_q == MODE_RELOAD ? en_q : 1'b0;
        state_d = mode_q == MODE_RELOAD ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ctrl_wr) begin
      en_d   = Data_In[CTRL_EN];
      mode_d = Data_In[CTRL_MODE +: 2];
      im_d   = Data_In[CTRL_IM];
      irq_d  = 1'b0;
    end
    if (Write_Enabled && Addr == ADDR_PRESET) preset_d = Data_In;
  end
  // timer state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      irq_q    <= 1'b0;
      preset_q <= RESET_PRESET;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      irq_q    <= irq_d;
      preset_q <= preset_d;
      count_q  <= count_d;
    end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed self-checking bench for interval_timer
`timescale 1ns/100ps
module tb_interval_timer;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Addr;
  logic        Write_Enabled;
  logic [31:0] Data_In, Data_Out;
  logic        IRQ;
  int pass_cnt = 0, total_cnt = 0;

  always #10 clk = ~clk;

  interval_timer #(.RESET_PRESET(32'd17), .PRESCALE_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .Addr         (Addr),
    .Write_Enabled(Write_Enabled),
    .Data_In      (Data_In),
    .Data_Out     (Data_Out),
    .IRQ          (IRQ)
  );

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a; Data_In = d; Write_Enabled = 1'b1;
    @(posedge clk);
    #1 Write_Enabled = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1 v = Data_Out;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst = 1'b1; Write_Enabled = 1'b0; Addr = 2'd0; Data_In = 32'd0;
    step(2);
    if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'd0) $display("FAIL reset_ctrl: got %0h want 0", v); else pass_cnt++; total_cnt++;
    rd(2'd1, v); if (v !== 32'd17) $display("FAIL reset_preset: got %0d want 17", v); else pass_cnt++; total_cnt++;
    rd(2'd2, v); if (v !== 32'd0) $display("FAIL reset_count: got %0d want 0", v); else pass_cnt++; total_cnt++;
    rd(2'd3, v); if (v !== 32'd0) $display("FAIL reset_rsvd: got %0h want 0", v); else pass_cnt++; total_cnt++;
    @(negedge clk) rst = 1'b0;
    step(1);
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      if (IRQ !== (k >= 7)) $display("FAIL oneshot_irq k=%0d: got %b want %b", k, IRQ, k >= 7); else pass_cnt++; total_cnt++;
      if (k >= 2) begin
        rd(2'd2, v);
        if (v !== 32'(7 - k)) $display("FAIL oneshot_count k=%0d: got %0d want %0d", k, v, 7 - k); else pass_cnt++; total_cnt++;
      end
    end
    step(3);
    if (IRQ !== 1'b1) $display("FAIL oneshot_hold: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'h8) $display("FAIL oneshot_en_clear: got %0h want 8", v); else pass_cnt++; total_cnt++;
    rd(2'd2, v); if (v !== 32'd0) $display("FAIL oneshot_count_end: got %0d want 0", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h0);
    if (IRQ !== 1'b0) $display("FAIL oneshot_ack: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_reload;
    logic [31:0] v, ec;
    logic ei;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      ei = k >= 5 && (k - 5) % 5 == 0;
      ec = k < 2 ? 32'd0 : ((k - 2) % 5 <= 3 ? 32'(3 - (k - 2) % 5) : 32'd0);
      if (IRQ !== ei) $display("FAIL reload_irq k=%0d: got %b want %b", k, IRQ, ei); else pass_cnt++; total_cnt++;
      rd(2'd2, v);
      if (v !== ec) $display("FAIL reload_count k=%0d: got %0d want %0d", k, v, ec); else pass_cnt++; total_cnt++;
    end
    wr(2'd0, 32'h0);
    step(3);
  endtask

  task automatic test_preset_zero;
    logic [31:0] v;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      if (IRQ !== (k == 3)) $display("FAIL zero_irq k=%0d: got %b want %b", k, IRQ, k == 3); else pass_cnt++; total_cnt++;
    end
    wr(2'd0, 32'h0);
    wr(2'd0, 32'hD);
    step(3);
    if (IRQ !== 1'b1) $display("FAIL mode10_irq: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    step(2);
    if (IRQ !== 1'b1) $display("FAIL mode10_hold: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'hC) $display("FAIL mode10_ctrl: got %0h want c", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h0);
    wr(2'd0, 32'h1);
    step(4);
    if (IRQ !== 1'b0) $display("FAIL masked_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'h0) $display("FAIL masked_ctrl: got %0h want 0", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h8);
    if (IRQ !== 1'b0) $display("FAIL unmask_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    step(1);
    if (IRQ !== 1'b0) $display("FAIL unmask_irq2: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_disable;
    logic [31:0] v;
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    step(20);
    wr(2'd1, 32'd7);
    rd(2'd2, v); if (v !== 32'd81) $display("FAIL midwrite_count: got %0d want 81", v); else pass_cnt++; total_cnt++;
    step(20);
    rd(2'd2, v); if (v !== 32'd61) $display("FAIL count_61: got %0d want 61", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h8);
    step(5);
    rd(2'd2, v); if (v !== 32'd60) $display("FAIL hold_count: got %0d want 60", v); else pass_cnt++; total_cnt++;
    if (IRQ !== 1'b0) $display("FAIL hold_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd1, v); if (v !== 32'd7) $display("FAIL preset_rb: got %0d want 7", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h9);
    step(1);
    rd(2'd2, v); if (v !== 32'd60) $display("FAIL reen_load: got %0d want 60", v); else pass_cnt++; total_cnt++;
    step(1);
    rd(2'd2, v); if (v !== 32'd7) $display("FAIL reen_count: got %0d want 7", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h0);
    step(3);
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    step(3);
    if (IRQ !== 1'b0) $display("FAIL b2b_pre: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h9);
    if (IRQ !== 1'b0) $display("FAIL b2b_setclr: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    step(1);
    rd(2'd0, v); if (v !== 32'h8) $display("FAIL b2b_int_en: got %0h want 8", v); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h9);
    step(4);
    if (IRQ !== 1'b1) $display("FAIL b2b_irq: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h9);
    if (IRQ !== 1'b0) $display("FAIL b2b_wr_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'h9) $display("FAIL b2b_wr_wins: got %0h want 9", v); else pass_cnt++; total_cnt++;
    step(3);
    if (IRQ !== 1'b0) $display("FAIL b2b_rerun_pre: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    step(1);
    if (IRQ !== 1'b1) $display("FAIL b2b_rerun_irq: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    wr(2'd0, 32'h8);
    step(1);
    rd(2'd2, v); if (v !== 32'd5) $display("FAIL load_dis_count: got %0d want 5", v); else pass_cnt++; total_cnt++;
    step(5);
    rd(2'd2, v); if (v !== 32'd5) $display("FAIL load_dis_hold: got %0d want 5", v); else pass_cnt++; total_cnt++;
    if (IRQ !== 1'b0) $display("FAIL load_dis_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
  endtask

  task automatic test_async_reset;
    logic [31:0] v;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step(5);
    if (IRQ !== 1'b1) $display("FAIL arst_pre_irq: got %b want 1", IRQ); else pass_cnt++; total_cnt++;
    #3 rst = 1'b1;
    #1;
    if (IRQ !== 1'b0) $display("FAIL arst_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
    rd(2'd0, v); if (v !== 32'd0) $display("FAIL arst_ctrl: got %0h want 0", v); else pass_cnt++; total_cnt++;
    rd(2'd1, v); if (v !== 32'd17) $display("FAIL arst_preset: got %0d want 17", v); else pass_cnt++; total_cnt++;
    rd(2'd2, v); if (v !== 32'd0) $display("FAIL arst_count: got %0d want 0", v); else pass_cnt++; total_cnt++;
    @(negedge clk) rst = 1'b0;
    step(3);
    rd(2'd2, v); if (v !== 32'd0) $display("FAIL arst_idle_count: got %0d want 0", v); else pass_cnt++; total_cnt++;
    if (IRQ !== 1'b0) $display("FAIL arst_idle_irq: got %b want 0", IRQ); else pass_cnt++; total_cnt++;
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale;
    logic [31:0] v, ec;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h29);
    rd(2'd0, v); if (v !== 32'h29) $display("FAIL ps_ctrl: got %0h want 29", v); else pass_cnt++; total_cnt++;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (IRQ !== (k >= 8)) $display("FAIL ps_irq k=%0d: got %b want %b", k, IRQ, k >= 8); else pass_cnt++; total_cnt++;
      if (k >= 2) begin
        ec = k < 5 ? 32'd2 : (k < 8 ? 32'd1 : 32'd0);
        rd(2'd2, v);
        if (v !== ec) $display("FAIL ps_count k=%0d: got %0d want %0d", k, v, ec); else pass_cnt++; total_cnt++;
      end
    end
    wr(2'd0, 32'h0);
  endtask
`endif

  initial begin
    test_reset;
    test_oneshot;
    test_reload;
    test_preset_zero;
    test_disable;
    test_back_to_back;
    test_async_reset;
`ifdef TIMER_PRESCALE_EN
    test_prescale;
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
